// File: rtl/exu_div_iter_if.sv
// Divide request/response bundle between decode and the iterative EXU divider.
interface exu_div_iter_if #(
    parameter int unsigned XLEN = 32
);
    logic            dp_valid;
    logic            dp_unsign;
    logic            dp_rem;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            flush;
    logic            fast_div_disable;
    logic            div_busy;
    logic            div_finish;
    logic [XLEN-1:0] div_result;

    modport master (
        output dp_valid, dp_unsign, dp_rem, dividend, divisor, flush, fast_div_disable,
        input  div_busy, div_finish, div_result
    );

    modport slave (
        input  dp_valid, dp_unsign, dp_rem, dividend, divisor, flush, fast_div_disable,
        output div_busy, div_finish, div_result
    );
endinterface

// File: rtl/exu_div_iter.sv
// Iterative restoring integer divider, radix 2^BITS_PER_CYCLE, with divide-by-zero,
// signed-overflow and small-dividend fast paths plus leading-zero iteration skip.
module exu_div_iter #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter bit          FAST_DIV_EN    = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    exu_div_iter_if.slave bus
);
    localparam int unsigned BPC   = BITS_PER_CYCLE;
    localparam int unsigned W     = XLEN + BPC;
    localparam int unsigned ITERS = XLEN / BPC;
    localparam int unsigned CNT_W = $clog2(ITERS + 1);
    localparam int unsigned NDIG  = 1 << BPC;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_SPECIAL, S_RUN, S_FIX, S_DONE} state_t;

    state_t          state;
    logic            busy;
    logic            finish;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] b_q;
    logic [CNT_W-1:0] cnt;
    logic            neg_q;
    logic            neg_r;
    logic            sel_rem;

    // Operand decode at accept time
    logic            accept;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            fast_en;
    logic            special;
    logic [XLEN-1:0] spec_val;
    int unsigned     lz;
    int unsigned     skip;
    int unsigned     iters;

    assign accept  = bus.dp_valid && !busy && !bus.flush;
    assign a_neg   = !bus.dp_unsign && bus.dividend[XLEN-1];
    assign b_neg   = !bus.dp_unsign && bus.divisor[XLEN-1];
    assign a_mag   = a_neg ? -bus.dividend : bus.dividend;
    assign b_mag   = b_neg ? -bus.divisor  : bus.divisor;
    assign fast_en = FAST_DIV_EN && !bus.fast_div_disable;

    // Fast-path detection in priority order; values are already final
    always_comb begin
        special  = 1'b1;
        spec_val = '0;
        if (bus.divisor == '0) begin
            spec_val = bus.dp_rem ? bus.dividend : '1;
        end else if (!bus.dp_unsign && bus.dividend == MIN_VAL && bus.divisor == '1) begin
            spec_val = bus.dp_rem ? '0 : MIN_VAL;
        end else if (fast_en && (a_mag < b_mag)) begin
            spec_val = bus.dp_rem ? bus.dividend : '0;
        end else begin
            special = 1'b0;
        end
    end

    // Leading zeros of |A| rounded down to a whole digit become skipped iterations
    always_comb begin
        lz = XLEN;
        for (int unsigned i = 0; i < XLEN; i++) begin
            if (a_mag[i]) lz = XLEN - 1 - i;
        end
        skip  = fast_en ? (lz / BPC) * BPC : 0;
        iters = (XLEN - skip) / BPC;
    end

    // One radix-2^BPC restoring step: pick the largest k with k*|B| <= partial remainder
    logic [W-1:0]    r_sh;
    logic [W-1:0]    prod;
    logic [BPC-1:0]  digit;
    logic [XLEN-1:0] r_next;
    logic [XLEN-1:0] q_next;

    always_comb begin
        r_sh   = {rem_q, quo_q[XLEN-1 -: BPC]};
        prod   = '0;
        digit  = '0;
        r_next = r_sh[XLEN-1:0];
        for (int k = 1; k < NDIG; k++) begin
            prod = W'(b_q) * W'(k);
            if (prod <= r_sh) begin
                digit  = BPC'(k);
                r_next = XLEN'(r_sh - prod);
            end
        end
        q_next = {quo_q[XLEN-BPC-1:0], digit};
    end

    // Sign correction and quotient/remainder select
    logic [XLEN-1:0] fix_val;

    always_comb begin
        if (sel_rem) fix_val = neg_r ? -rem_q : rem_q;
        else         fix_val = neg_q ? -quo_q : quo_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            finish  <= 1'b0;
            result  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            b_q     <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            sel_rem <= 1'b0;
        end else begin
            finish <= 1'b0;
            if (bus.flush) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            busy    <= 1'b1;
                            sel_rem <= bus.dp_rem;
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                            b_q     <= b_mag;
                            rem_q   <= '0;
                            quo_q   <= a_mag << skip;
                            cnt     <= CNT_W'(iters);
                            if (special) begin
                                result <= spec_val;
                                finish <= 1'b1;
                                state  <= S_SPECIAL;
                            end else begin
                                state  <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        rem_q <= r_next;
                        quo_q <= q_next;
                        cnt   <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) state <= S_FIX;
                    end
                    S_FIX: begin
                        result <= fix_val;
                        finish <= 1'b1;
                        state  <= S_DONE;
                    end
                    // Fast-path ops finish in the cycle right after accept
                    S_SPECIAL, S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.div_busy   = busy;
    assign bus.div_finish = finish;
    assign bus.div_result = result;

endmodule

// File: tb/tb_exu_div_iter.sv
// Bench for exu_div_iter: five width/radix/fast-path builds driven in lockstep and
// checked for result, latency and busy window against an arithmetic reference.
module tb_exu_div_iter;
    localparam int ND = 5;

    function automatic int unsigned xl_of(input int g);
        return (g < 3) ? 32 : 64;
    endfunction
    function automatic int unsigned bpc_of(input int g);
        case (g)
            0: return 1;
            1: return 2;
            2: return 4;
            3: return 2;
            default: return 4;
        endcase
    endfunction
    function automatic bit fe_of(input int g);
        return g != 4;
    endfunction

    logic clk = 1'b0;
    logic rst;
    logic valid, uns, rs, flush, fdis;
    logic [63:0] a_in, b_in;

    logic [ND-1:0] fin_vec;
    logic [ND-1:0] busy_vec;
    logic [63:0]   res_arr [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int unsigned WG = xl_of(g);
        exu_div_iter_if #(.XLEN(WG)) bus ();
        exu_div_iter #(
            .XLEN(WG), .BITS_PER_CYCLE(bpc_of(g)), .FAST_DIV_EN(fe_of(g))
        ) dut (
            .clk(clk), .rst(rst), .bus(bus.slave)
        );
        assign bus.dp_valid         = valid;
        assign bus.dp_unsign        = uns;
        assign bus.dp_rem           = rs;
        assign bus.dividend         = a_in[WG-1:0];
        assign bus.divisor          = b_in[WG-1:0];
        assign bus.flush            = flush;
        assign bus.fast_div_disable = fdis;
        assign fin_vec[g]  = bus.div_finish;
        assign busy_vec[g] = bus.div_busy;
        assign res_arr[g]  = 64'(bus.div_result);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Cumulative observations; tests work on deltas from a snapshot
    int          fin_seen [ND];
    int          fin_at   [ND];
    int          busy_cnt [ND];
    logic [63:0] fin_val  [ND];
    initial for (int g = 0; g < ND; g++) begin
        fin_seen[g] = 0; fin_at[g] = 0; busy_cnt[g] = 0; fin_val[g] = '0;
    end

    always @(negedge clk) begin
        for (int g = 0; g < ND; g++) begin
            if (fin_vec[g] === 1'b1) begin
                fin_seen[g] = fin_seen[g] + 1;
                fin_at[g]   = cyc;
                fin_val[g]  = res_arr[g];
            end
            if (busy_vec[g] === 1'b1) busy_cnt[g] = busy_cnt[g] + 1;
        end
    end

    int          n_chk = 0;
    int          n_fail = 0;
    int          t0;
    int          sn_fin  [ND];
    int          sn_busy [ND];
    int          exp_lat [ND];
    logic [63:0] exp_val [ND];
    logic [63:0] prev    [ND];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] mask_of(input int unsigned w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Reference quotient/remainder from plain integer arithmetic
    function automatic logic [63:0] ref_val(input int unsigned w, input bit u, input bit r,
                                            input logic [63:0] a0, input logic [63:0] b0);
        logic [63:0] m, a, b, minw;
        longint sa, sb;
        m = mask_of(w); a = a0 & m; b = b0 & m;
        minw = (w == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
        if (b == 0) return r ? a : m;
        if (u) return r ? (a % b) : (a / b);
        if (w == 64 && a == minw && b == m) return r ? 64'd0 : minw;
        if (w == 32) begin
            sa = longint'($signed(a[31:0]));
            sb = longint'($signed(b[31:0]));
        end else begin
            sa = $signed(a);
            sb = $signed(b);
        end
        return (r ? 64'(sa % sb) : 64'(sa / sb)) & m;
    endfunction

    // Reference finish latency (cycles after the accept cycle)
    function automatic int ref_lat(input int unsigned w, input int unsigned bpc, input bit fast,
                                   input bit u, input logic [63:0] a0, input logic [63:0] b0);
        logic [63:0] m, a, b, minw, am, bm;
        int lz, skip;
        m = mask_of(w); a = a0 & m; b = b0 & m;
        minw = (w == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
        am = (!u && (a & minw) != 0) ? ((-a) & m) : a;
        bm = (!u && (b & minw) != 0) ? ((-b) & m) : b;
        if (b == 0) return 1;
        if (!u && a == minw && b == m) return 1;
        if (fast && am < bm) return 1;
        lz = 0;
        for (int i = int'(w) - 1; i >= 0; i--) begin
            if (am[i]) break;
            lz++;
        end
        skip = fast ? (lz / int'(bpc)) * int'(bpc) : 0;
        return (int'(w) - skip) / int'(bpc) + 2;
    endfunction

    task automatic snap();
        for (int g = 0; g < ND; g++) begin
            sn_fin[g]  = fin_seen[g];
            sn_busy[g] = busy_cnt[g];
        end
    endtask

    // Present an op in the current (idle) cycle T; returns in cycle T+1
    task automatic start(input bit u, input bit r, input logic [63:0] a, input logic [63:0] b,
                         input bit fd);
        uns = u; rs = r; a_in = a; b_in = b; fdis = fd; valid = 1'b1;
        t0 = cyc;
        snap();
        for (int g = 0; g < ND; g++) begin
            exp_val[g] = ref_val(xl_of(g), u, r, a, b);
            exp_lat[g] = ref_lat(xl_of(g), bpc_of(g), fe_of(g) && !fd, u, a, b);
        end
        step();
        valid = 1'b0;
    endtask

    function automatic bit all_done();
        for (int g = 0; g < ND; g++) if (fin_seen[g] <= sn_fin[g]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic finish_chk(input string tag);
        int guard;
        guard = 0;
        while (!all_done() && guard < 200) begin
            step();
            guard++;
        end
        step();
        step();
        for (int g = 0; g < ND; g++) begin
            chk($sformatf("%s g%0d pulses", tag, g), 64'(fin_seen[g] - sn_fin[g]), 64'd1);
            chk($sformatf("%s g%0d latency", tag, g), 64'(fin_at[g] - t0), 64'(exp_lat[g]));
            chk($sformatf("%s g%0d result", tag, g), fin_val[g], exp_val[g]);
            chk($sformatf("%s g%0d busy_cycles", tag, g), 64'(busy_cnt[g] - sn_busy[g]),
                64'(exp_lat[g]));
            chk($sformatf("%s g%0d busy_after", tag, g), 64'(busy_vec[g]), 64'd0);
        end
    endtask

    task automatic quiet_chk(input string tag, input bit cmp_prev);
        for (int g = 0; g < ND; g++) begin
            chk($sformatf("%s g%0d no_finish", tag, g), 64'(fin_seen[g] - sn_fin[g]), 64'd0);
            chk($sformatf("%s g%0d busy", tag, g), 64'(busy_vec[g]), 64'd0);
            chk($sformatf("%s g%0d result", tag, g), res_arr[g], cmp_prev ? prev[g] : 64'd0);
        end
    endtask

    function automatic logic [63:0] rnd_op();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0: v = {$urandom, $urandom};
            1: v = 64'($urandom_range(0, 300));
            2: begin v = {$urandom, $urandom}; v = v >> $urandom_range(0, 63); end
            3: v = -64'($urandom_range(1, 50));
            4: v = $urandom_range(0, 1) ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_8000_0000;
            default: v = $urandom_range(0, 1) ? 64'd0 : 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return v;
    endfunction

    initial begin
        rst = 1'b1; valid = 1'b0; uns = 1'b0; rs = 1'b0; flush = 1'b0; fdis = 1'b0;
        a_in = '0; b_in = '0;
        step(); step(); step();
        for (int g = 0; g < ND; g++) begin
            chk($sformatf("reset g%0d busy", g), 64'(busy_vec[g]), 64'd0);
            chk($sformatf("reset g%0d finish", g), 64'(fin_vec[g]), 64'd0);
            chk($sformatf("reset g%0d result", g), res_arr[g], 64'd0);
        end
        rst = 1'b0;
        step();

        // Directed ops from the plan, plus explicit constants for the baseline build
        start(1, 0, 64'h100, 64'h2, 1); finish_chk("u100_2_slow");
        chk("u100_2_slow lat32b1", 64'(fin_at[0] - t0), 64'd34);
        chk("u100_2_slow val32b1", fin_val[0], 64'h80);
        start(1, 0, 64'h100, 64'h2, 0); finish_chk("u100_2_fast");
        chk("u100_2_fast lat32b1", 64'(fin_at[0] - t0), 64'd11);
        start(1, 0, 64'h5, 64'h9, 0); finish_chk("u5_9_quot");
        chk("u5_9_quot lat32b1", 64'(fin_at[0] - t0), 64'd1);
        start(1, 1, 64'h5, 64'h9, 0); finish_chk("u5_9_rem");
        chk("u5_9_rem val32b1", fin_val[0], 64'h5);
        start(0, 0, -64'd7, 64'd2, 0); finish_chk("s-7_2_quot");
        chk("s-7_2_quot val32b1", fin_val[0], 64'hFFFF_FFFD);
        start(0, 1, -64'd7, 64'd2, 0); finish_chk("s-7_2_rem");
        chk("s-7_2_rem val32b1", fin_val[0], 64'hFFFF_FFFF);
        start(0, 1, 64'd7, -64'd2, 0); finish_chk("s7_-2_rem");
        chk("s7_-2_rem val32b1", fin_val[0], 64'h1);
        start(1, 0, 64'h5, 64'h0, 0); finish_chk("div0_quot");
        start(1, 1, 64'h5, 64'h0, 0); finish_chk("div0_rem");
        chk("div0_rem val32b1", fin_val[0], 64'h5);
        start(0, 0, 64'h8000_0000, 64'hFFFF_FFFF, 0); finish_chk("ovf32_quot");
        chk("ovf32_quot val32b1", fin_val[0], 64'h8000_0000);
        start(0, 1, 64'h8000_0000, 64'hFFFF_FFFF, 0); finish_chk("ovf32_rem");
        start(0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0); finish_chk("ovf64_quot");
        start(1, 0, 64'hFFFF_FFFF, 64'h3, 1); finish_chk("uffff_3");
        chk("uffff_3 lat32b4", 64'(fin_at[2] - t0), 64'd10);
        chk("uffff_3 val32b4", fin_val[2], 64'h5555_5555);

        // Flush at T+5 kills the op; a new op accepted at T+6 completes
        for (int g = 0; g < ND; g++) prev[g] = res_arr[g];
        start(1, 0, 64'h100, 64'h2, 1);
        step(); step(); step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        quiet_chk("flush_mid", 1'b1);
        start(0, 0, -64'd1000, 64'd7, 1); finish_chk("after_flush");

        // Flush together with dp_valid drops the request
        for (int g = 0; g < ND; g++) prev[g] = res_arr[g];
        snap();
        uns = 1'b1; rs = 1'b0; a_in = 64'h5; b_in = 64'h0; valid = 1'b1; flush = 1'b1;
        step();
        valid = 1'b0; flush = 1'b0;
        step(); step();
        quiet_chk("flush_with_valid", 1'b1);

        // dp_valid while busy is ignored
        start(0, 0, -64'd100, 64'd7, 1);
        a_in = 64'h9; b_in = 64'h0; valid = 1'b1;
        step();
        valid = 1'b0;
        finish_chk("valid_while_busy");

        // Flush landing in the last finish cycle does not suppress the pulse
        begin
            int mx;
            start(1, 0, 64'h100, 64'h2, 1);
            mx = 0;
            for (int g = 0; g < ND; g++) if (exp_lat[g] > mx) mx = exp_lat[g];
            while (cyc < t0 + mx) step();
            flush = 1'b1;
            step();
            flush = 1'b0;
            finish_chk("flush_in_done");
        end

        // Reset mid-operation clears the result
        start(1, 0, 64'h100, 64'h2, 1);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        quiet_chk("rst_mid", 1'b0);
        step();

        // Randomized sweep
        for (int n = 0; n < 70; n++) begin
            start(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_op(), rnd_op(),
                  1'($urandom_range(0, 1)));
            finish_chk($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
